// File: rtl/ccip_avmm_csr_slave.sv
// Avalon-MM CSR responder for the AFU side of the CCI-P MMIO bridge.
// Provides the DFH/AFU ID header, scratch registers and access counters.
// Reads use a fixed pipelined latency. Only 64-bit words are decoded.
module ccip_avmm_csr_slave #(
  parameter logic [63:0] DFH_VALUE                 = 64'h1000_0000_0000_0000,
  parameter logic [63:0] AFU_ID_L                  = 64'h0,
  parameter logic [63:0] AFU_ID_H                  = 64'h0,
  parameter int          NUM_SCRATCH               = 4,
  parameter int          READ_LATENCY              = 2,
  parameter int          CCIP_AVMM_MMIO_ADDR_WIDTH = 16,
  parameter int          CCIP_AVMM_MMIO_DATA_WIDTH = 64
) (
  input  logic                                 clk,
  input  logic                                 reset,
  output logic                                 avmm_waitrequest,
  input  logic [CCIP_AVMM_MMIO_ADDR_WIDTH-1:0] avmm_address,
  input  logic                                 avmm_read,
  input  logic                                 avmm_write,
  input  logic [CCIP_AVMM_MMIO_DATA_WIDTH-1:0] avmm_writedata,
  input  logic [7:0]                           avmm_byteenable,
  output logic [CCIP_AVMM_MMIO_DATA_WIDTH-1:0] avmm_readdata,
  output logic                                 avmm_readdatavalid
);

  localparam int AW = CCIP_AVMM_MMIO_ADDR_WIDTH;
  localparam int DW = CCIP_AVMM_MMIO_DATA_WIDTH;
  localparam int IW = AW - 3;
  localparam int SW = (NUM_SCRATCH > 1) ? $clog2(NUM_SCRATCH) : 1;

  logic          reset_d;
  logic          waitreq_q;
  logic [IW-1:0] idx;
  logic [IW-1:0] scr_off;
  logic [SW-1:0] scr_sel;
  logic          scr_hit;
  logic          wr_acc;
  logic          rd_acc;
  logic [DW-1:0] rd_val;
  logic [DW-1:0] scratch [NUM_SCRATCH];
  logic [63:0]   wr_count;
  logic [63:0]   rd_count;
  logic [READ_LATENCY-1:0] vld_sr;
  logic [DW-1:0]           data_sr [READ_LATENCY];

  // byte offset bits are never decoded; the bridge selects 32-bit halves
  logic unused_addr_lsb;
  assign unused_addr_lsb = &{1'b0, avmm_address[2:0]};

  assign idx     = avmm_address[AW-1:3];
  assign scr_off = idx - IW'(8);
  assign scr_sel = scr_off[SW-1:0];
  assign scr_hit = (idx >= IW'(8)) && (scr_off < IW'(NUM_SCRATCH));

  // read+write together is treated as a write only
  assign wr_acc = avmm_write & ~waitreq_q;
  assign rd_acc = avmm_read & ~avmm_write & ~waitreq_q;

  assign avmm_waitrequest   = waitreq_q;
  assign avmm_readdatavalid = vld_sr[READ_LATENCY-1];
  assign avmm_readdata      = data_sr[READ_LATENCY-1];

  // stall while in reset and for one extra cycle after reset drops
  always_ff @(posedge clk) begin
    if (reset) begin
      reset_d   <= 1'b1;
      waitreq_q <= 1'b1;
    end else begin
      reset_d   <= 1'b0;
      waitreq_q <= reset_d;
    end
  end

  // register map read mux, sampled in the accept cycle
  always_comb begin
    rd_val = '0;
    if (idx == IW'(0))      rd_val = DW'(DFH_VALUE);
    else if (idx == IW'(1)) rd_val = DW'(AFU_ID_L);
    else if (idx == IW'(2)) rd_val = DW'(AFU_ID_H);
    else if (idx == IW'(6)) rd_val = DW'(wr_count);
    else if (idx == IW'(7)) rd_val = DW'(rd_count);
    else if (scr_hit)       rd_val = scratch[scr_sel];
  end

  // scratch registers with per-byte enables
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_SCRATCH; i++) scratch[i] <= '0;
    end else if (wr_acc && scr_hit) begin
      for (int b = 0; b < 8; b++) begin
        if (avmm_byteenable[b]) scratch[scr_sel][8*b +: 8] <= avmm_writedata[8*b +: 8];
      end
    end
  end

  // access counters; a write to a counter clears it and suppresses its own count
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_count <= '0;
      rd_count <= '0;
    end else begin
      if (wr_acc) wr_count <= (idx == IW'(6)) ? 64'd0 : wr_count + 64'd1;
      if (wr_acc && idx == IW'(7)) rd_count <= 64'd0;
      else if (rd_acc)             rd_count <= rd_count + 64'd1;
    end
  end

  // fixed-latency read pipeline; reset drops any reads in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_sr <= '0;
      for (int i = 0; i < READ_LATENCY; i++) data_sr[i] <= '0;
    end else begin
      vld_sr[0]  <= rd_acc;
      data_sr[0] <= rd_val;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_sr[i]  <= vld_sr[i-1];
        data_sr[i] <= data_sr[i-1];
      end
    end
  end

endmodule

// File: tb/tb_ccip_avmm_csr_slave.sv
// Scoreboard bench for ccip_avmm_csr_slave: directed sequences plus random traffic
// checked against a word-level register model.
module tb_ccip_avmm_csr_slave;
  localparam int AW  = 16;
  localparam int DW  = 64;
  localparam int LAT = 2;
  localparam int NS  = 4;
  localparam logic [63:0] DFH = 64'h1000_0000_0000_0001;
  localparam logic [63:0] IDL = 64'h0;
  localparam logic [63:0] IDH = 64'h0;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          avmm_waitrequest;
  logic [AW-1:0] avmm_address = '0;
  logic          avmm_read = 1'b0;
  logic          avmm_write = 1'b0;
  logic [DW-1:0] avmm_writedata = '0;
  logic [7:0]    avmm_byteenable = '0;
  logic [DW-1:0] avmm_readdata;
  logic          avmm_readdatavalid;

  ccip_avmm_csr_slave #(
    .DFH_VALUE(DFH), .AFU_ID_L(IDL), .AFU_ID_H(IDH),
    .NUM_SCRATCH(NS), .READ_LATENCY(LAT),
    .CCIP_AVMM_MMIO_ADDR_WIDTH(AW), .CCIP_AVMM_MMIO_DATA_WIDTH(DW)
  ) dut (
    .clk(clk), .reset(reset),
    .avmm_waitrequest(avmm_waitrequest),
    .avmm_address(avmm_address),
    .avmm_read(avmm_read),
    .avmm_write(avmm_write),
    .avmm_writedata(avmm_writedata),
    .avmm_byteenable(avmm_byteenable),
    .avmm_readdata(avmm_readdata),
    .avmm_readdatavalid(avmm_readdatavalid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [63:0] data;
    int          due;
    logic [15:0] addr;
  } exp_t;
  exp_t exp_q[$];

  logic [63:0] m_scr [NS];
  logic [63:0] m_wr;
  logic [63:0] m_rd;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [63:0] ref_read(input logic [15:0] a);
    int w;
    w = int'(a) / 8;
    if (w == 0) return DFH;
    if (w == 1) return IDL;
    if (w == 2) return IDH;
    if (w == 6) return m_wr;
    if (w == 7) return m_rd;
    if (w >= 8 && w < 8 + NS) return m_scr[w-8];
    return 64'h0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NS; i++) m_scr[i] = '0;
    m_wr = '0;
    m_rd = '0;
    exp_q.delete();
  endtask

  // called at a negedge; returns one negedge after the command is accepted
  task automatic issue(input bit rd, input bit wr, input logic [15:0] a,
                       input logic [63:0] d, input logic [7:0] be);
    int   g;
    int   w;
    exp_t e;
    g = 0;
    avmm_read = rd; avmm_write = wr; avmm_address = a;
    avmm_writedata = d; avmm_byteenable = be;
    while (avmm_waitrequest && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (avmm_waitrequest) begin
      total++; bad++;
      $display("FAIL accept_timeout: waitrequest still %b expected 0 at addr %h", avmm_waitrequest, a);
    end else begin
      w = int'(a) / 8;
      if (wr) begin
        if (w == 6) m_wr = 0; else m_wr = m_wr + 1;
        if (w == 7) m_rd = 0;
        if (w >= 8 && w < 8 + NS)
          for (int b = 0; b < 8; b++) if (be[b]) m_scr[w-8][8*b +: 8] = d[8*b +: 8];
      end else if (rd) begin
        e.data = ref_read(a);
        e.due  = cyc + LAT;
        e.addr = a;
        exp_q.push_back(e);
        m_rd = m_rd + 1;
      end
    end
    @(negedge clk);
    avmm_read = 1'b0; avmm_write = 1'b0;
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("wait_in_reset", 64'(avmm_waitrequest), 64'd1);
      check("valid_in_reset", 64'(avmm_readdatavalid), 64'd0);
    end
    check("rdata_in_reset", avmm_readdata, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("wait_cycle1", 64'(avmm_waitrequest), 64'd1);
    @(negedge clk);
    check("wait_cycle2", 64'(avmm_waitrequest), 64'd0);
  endtask

  // monitor: every valid must match the oldest outstanding read, at its due cycle
  always @(negedge clk) begin
    exp_t e;
    if (avmm_readdatavalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_valid: got valid=1 data %h expected no valid", avmm_readdata);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("rdata@%h", e.addr), avmm_readdata, e.data);
        check("rd_latency", 64'(cyc), 64'(e.due));
      end
    end
  end

  logic [15:0] quad [4];

  initial begin
    int g;
    int op;
    logic [15:0] a;
    logic [7:0]  be;
    quad[0] = 16'h0008; quad[1] = 16'h0010; quad[2] = 16'h0048; quad[3] = 16'h03F8;

    @(negedge clk);
    apply_reset(5);

    issue(1, 0, 16'h0000, 0, 0);
    repeat (3) @(negedge clk);

    issue(0, 1, 16'h0040, 64'hAAAA_BBBB_CCCC_DDDD, 8'hFF);
    issue(0, 1, 16'h0040, 64'h1111_2222_3333_4444, 8'hF0);
    issue(1, 0, 16'h0040, 0, 0);
    repeat (3) @(negedge clk);

    issue(0, 1, 16'h0038, 64'h0, 8'hFF);
    for (int i = 0; i < 16; i++) issue(1, 0, quad[i % 4], 0, 0);
    repeat (3) @(negedge clk);
    issue(1, 0, 16'h0038, 0, 0);
    repeat (3) @(negedge clk);

    for (int i = 0; i < 3; i++) issue(0, 1, 16'h0048, 64'(i) * 64'h0101_0101, 8'hFF);
    issue(0, 1, 16'h0030, 64'h0, 8'h00);
    issue(1, 0, 16'h0030, 0, 0);
    issue(0, 1, 16'h0050, 64'h5555_6666_7777_8888, 8'h00);
    issue(1, 0, 16'h0030, 0, 0);
    issue(1, 0, 16'h0050, 0, 0);
    issue(1, 1, 16'h0058, 64'hDEAD_BEEF_0000_0001, 8'h0F);
    issue(1, 0, 16'h0058, 0, 0);
    issue(1, 0, 16'h0038, 0, 0);
    repeat (3) @(negedge clk);

    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 9);
      a  = 16'($urandom_range(0, 17) * 8 + $urandom_range(0, 7));
      be = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      if (op <= 3)      issue(1, 0, a, 0, 0);
      else if (op <= 7) issue(0, 1, a, {$urandom, $urandom}, be);
      else if (op == 8) issue(1, 1, a, {$urandom, $urandom}, be);
      else              @(negedge clk);
    end
    issue(0, 1, 16'h0040, 64'h0123_4567_89AB_CDEF, 8'hFF);
    repeat (4) @(negedge clk);

    issue(1, 0, 16'h0000, 0, 0);
    apply_reset(3);
    repeat (2) @(negedge clk);
    issue(1, 0, 16'h0038, 0, 0);
    issue(1, 0, 16'h0030, 0, 0);
    for (int i = 0; i < NS; i++) issue(1, 0, 16'(16'h0040 + 8 * i), 0, 0);
    issue(1, 0, 16'h0000, 0, 0);

    g = 0;
    while (exp_q.size() > 0 && g < 20) begin
      @(negedge clk);
      g++;
    end
    check("drain_pending", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
